pipe_stage_reg: RTL and testbench

- Parametrised, handshaked pipeline stage register.
- Generalises the fixed four-word EX/MA latch to N packed XLEN-bit fields.
- Adds valid/ready flow control, stall, flush-to-bubble, and an optional skid entry.
- Sits between any two CPU pipeline stages (IF/ID, ID/EX, EX/MA, MA/WB); the hazard unit drives flush and downstream stalls.

---
 rtl/pipe_stage_reg.sv | 98 +++++++++
 tb/tb_pipe_stage_reg.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - handshaked pipeline stage register with optional skid entry
module pipe_stage_reg #(
  parameter int          XLEN      = 32,
  parameter int          NFIELDS   = 4,
  parameter int          INSTR_IDX = 3,
  parameter logic [31:0] NOP_INSTR = 32'h00000013,
  parameter int          SKID      = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NFIELDS*XLEN-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NFIELDS*XLEN-1:0] out_data
);

  localparam int W = NFIELDS * XLEN;
  localparam logic [XLEN-1:0] NOP_FIELD = XLEN'(NOP_INSTR);
  localparam logic [W-1:0]    BUBBLE    = W'(NOP_FIELD) << (INSTR_IDX * XLEN);

  if (INSTR_IDX >= NFIELDS) begin : g_bad_instr_idx
    $error("pipe_stage_reg: INSTR_IDX must be below NFIELDS");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   main_q, main_nxt;
  logic [W-1:0]   skid_q, skid_nxt;
  logic           ready_q;
  logic           in_fire;

  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  // With the skid entry, in_ready comes straight from a flop so out_ready never reaches it.
  assign in_ready  = (SKID != 0) ? ready_q : (!out_valid || out_ready);
  assign in_fire   = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    if (flush) begin
      state_nxt = EMPTY;
      main_nxt  = BUBBLE;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_nxt  = in_data;
            state_nxt = BUSY;
          end
        end
        BUSY: begin
          if (in_fire) begin
            if (out_ready) begin
              main_nxt = in_data;
            end else if (SKID != 0) begin
              skid_nxt  = in_data;
              state_nxt = FULL;
            end
          end else if (out_ready) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (out_ready) begin
            main_nxt  = skid_q;
            state_nxt = BUSY;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state   <= state_nxt;
      main_q  <= main_nxt;
      skid_q  <= skid_nxt;
      ready_q <= (state_nxt != FULL);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed and scoreboard bench for pipe_stage_reg
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // SKID=1, default widths
  logic         fl1 = 1'b0, iv1 = 1'b0, ir1, ov1, or1 = 1'b0;
  logic [127:0] id1 = '0, od1;
  // SKID=0, default widths
  logic         fl0 = 1'b0, iv0 = 1'b0, ir0, ov0, or0 = 1'b0;
  logic [127:0] id0 = '0, od0;
  // SKID=1, XLEN=64, NFIELDS=6, INSTR_IDX=5
  logic         flw = 1'b0, ivw = 1'b0, irw, ovw, orw = 1'b0;
  logic [383:0] idw = '0, odw;

  pipe_stage_reg #(.SKID(1)) u_skid (
    .clk(clk), .rst(rst), .flush(fl1), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1)
  );

  pipe_stage_reg #(.SKID(0)) u_single (
    .clk(clk), .rst(rst), .flush(fl0), .in_valid(iv0), .in_ready(ir0), .in_data(id0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0)
  );

  pipe_stage_reg #(.XLEN(64), .NFIELDS(6), .INSTR_IDX(5), .SKID(1)) u_wide (
    .clk(clk), .rst(rst), .flush(flw), .in_valid(ivw), .in_ready(irw), .in_data(idw),
    .out_valid(ovw), .out_ready(orw), .out_data(odw)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [383:0] got, input logic [383:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  localparam logic [31:0]  VA = 32'hAAAA0000, VB = 32'hBBBB0000, VC = 32'hCCCC0000;
  localparam logic [31:0]  VD = 32'hDDDD0000, VE = 32'hEEEE0000;
  localparam logic [31:0]  VX = 32'h11110000, VY = 32'h22220000;
  localparam logic [127:0] BUB128 = {32'h00000013, 96'h0};
  localparam logic [383:0] BUB384 = {64'h0000000000000013, 320'h0};

  logic [383:0] sb[$];
  logic [383:0] exp_w;

  initial begin
    // reset for two edges
    repeat (2) step();
    check("rst_ov1", 384'(ov1), 384'(0));
    check("rst_od1", 384'(od1), 384'(0));
    check("rst_ir1", 384'(ir1), 384'(1));
    check("rst_ov0", 384'(ov0), 384'(0));
    check("rst_ir0", 384'(ir0), 384'(1));
    check("rst_odw", odw, 384'(0));
    rst = 1'b0;

    // pass-through, both modes
    or1 = 1'b1; or0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      iv1 = 1'b1; id1 = 128'(32'h100 + 32'(4 * i));
      iv0 = 1'b1; id0 = 128'(32'h100 + 32'(4 * i));
      step();
      check("pt_ov1", 384'(ov1), 384'(1));
      check("pt_d1", 384'(od1[31:0]), 384'(32'h100 + 32'(4 * i)));
      check("pt_ir1", 384'(ir1), 384'(1));
      check("pt_ov0", 384'(ov0), 384'(1));
      check("pt_d0", 384'(od0[31:0]), 384'(32'h100 + 32'(4 * i)));
      check("pt_ir0", 384'(ir0), 384'(1));
    end
    iv1 = 1'b0; iv0 = 1'b0;
    step();
    check("pt_drain1", 384'(ov1), 384'(0));
    check("pt_drain0", 384'(ov0), 384'(0));

    // stall into the skid entry, then release
    or1 = 1'b0; iv1 = 1'b1; id1 = 128'(VA);
    step();
    id1 = 128'(VB);
    step();
    check("sk_ir_full", 384'(ir1), 384'(0));
    check("sk_ov", 384'(ov1), 384'(1));
    check("sk_hold_a", 384'(od1), 384'(VA));
    id1 = 128'(VC);
    step();
    check("sk_c_held", 384'(ir1), 384'(0));
    check("sk_still_a", 384'(od1), 384'(VA));
    or1 = 1'b1;
    step();
    check("sk_b", 384'(od1), 384'(VB));
    check("sk_ir_back", 384'(ir1), 384'(1));
    step();
    check("sk_c", 384'(od1), 384'(VC));
    check("sk_c_ov", 384'(ov1), 384'(1));
    iv1 = 1'b0;
    step();
    check("sk_empty", 384'(ov1), 384'(0));

    // flush a full stage while D is offered
    or1 = 1'b0; iv1 = 1'b1; id1 = 128'(VA);
    step();
    id1 = 128'(VB);
    step();
    check("fl_full", 384'(ir1), 384'(0));
    fl1 = 1'b1; id1 = 128'(VD);
    step();
    fl1 = 1'b0; iv1 = 1'b0; or1 = 1'b1;
    check("fl_ov", 384'(ov1), 384'(0));
    check("fl_bubble", 384'(od1), 384'(BUB128));
    check("fl_ir", 384'(ir1), 384'(1));
    repeat (2) begin
      step();
      check("fl_no_d", 384'(ov1), 384'(0));
    end

    // reset while full
    or1 = 1'b0; iv1 = 1'b1; id1 = 128'(VA);
    step();
    id1 = 128'(VB);
    step();
    id1 = 128'(VC); rst = 1'b1;
    step();
    rst = 1'b0;
    check("rm_ov", 384'(ov1), 384'(0));
    check("rm_od", 384'(od1), 384'(0));
    check("rm_ir", 384'(ir1), 384'(1));
    id1 = 128'(VE); or1 = 1'b1;
    step();
    iv1 = 1'b0;
    check("rm_e", 384'(od1), 384'(VE));
    check("rm_e_ov", 384'(ov1), 384'(1));
    repeat (2) begin
      step();
      check("rm_e_alone", 384'(ov1), 384'(0));
    end

    // single-entry backpressure
    or0 = 1'b0; iv0 = 1'b1; id0 = 128'(VX);
    step();
    id0 = 128'(VY);
    #1;
    check("s0_ir_stall", 384'(ir0), 384'(0));
    step();
    check("s0_hold", 384'(od0), 384'(VX));
    check("s0_ov", 384'(ov0), 384'(1));
    or0 = 1'b1;
    #1;
    check("s0_ir_go", 384'(ir0), 384'(1));
    step();
    check("s0_replaced", 384'(od0), 384'(VY));
    iv0 = 1'b0;
    step();
    check("s0_empty", 384'(ov0), 384'(0));

    // wide random valid/ready against an in-order scoreboard
    for (int c = 0; c < 10000; c++) begin
      ivw = 1'($urandom_range(0, 1));
      orw = 1'($urandom_range(0, 1));
      for (int k = 0; k < 12; k++) idw[k*32 +: 32] = $urandom();
      if (ovw && orw) begin
        if (sb.size() == 0) begin
          check("sw_unexpected", 384'(ovw), 384'(0));
        end else begin
          exp_w = sb.pop_front();
          check("sw_data", odw, exp_w);
        end
      end
      if (ivw && irw) sb.push_back(idw);
      step();
    end
    ivw = 1'b0; orw = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (ovw) begin
        if (sb.size() == 0) begin
          check("sw_unexpected", 384'(ovw), 384'(0));
        end else begin
          exp_w = sb.pop_front();
          check("sw_drain", odw, exp_w);
        end
      end
      step();
    end
    check("sw_left", 384'(sb.size()), 384'(0));
    check("sw_ov_end", 384'(ovw), 384'(0));

    // wide flush bubble position
    orw = 1'b0; ivw = 1'b1; idw = {12{32'hFFFFFFFF}};
    step();
    flw = 1'b1;
    step();
    flw = 1'b0; ivw = 1'b0;
    check("fw_ov", 384'(ovw), 384'(0));
    check("fw_bubble", odw, BUB384);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
